pause_sequencer: RTL and testbench
==================================

// Module: pause_sequencer
// PURPOSE
//  Merges all pause sources (user button toggle, OSD-open, NREQ external requesters such as hiscore/savestate).
//  Sequences CPU halt entry/exit on vblank boundaries with a halt_req/halt_ack handshake and ack timeout.
//  Sits between input/OSD logic and the CPU halt pin; its paused output feeds the video dimmer.
// PARAMETERS
//  NREQ         2     number of external level pause requesters
//  DEBOUNCE_CYC 12000 user_button stable cycles before accepted (1 ms @ 12 MHz)
//  ACK_TIMEOUT  4096  max cycles waiting on halt_ack (assert or deassert)
// PORTS
//  clk_sys     in   1       core system clock
//  reset       in   1       synchronous, active-high reset
//  user_button in   1       raw pause button, active-high
//  osd_status  in   1       OSD open
//  options     in   2       [0] pause when OSD open; [1] reserved, ignored
//  ext_req     in   NREQ    external level pause requests, active-high
//  vblank      in   1       video vertical blank, clk_sys domain
//  halt_ack    in   1       CPU reports halted at safe point
//  halt_req    out  1       halt request to CPU (registered)
//  paused      out  1       1 only in PAUSED state (registered)
//  pause_src   out  NREQ+2  source mask latched on PAUSED entry: [0] user, [1] OSD, [2+i] ext_req[i]
//  timeout_err out  1       one-cycle pulse on ack timeout
// BEHAVIOUR
//  Reset: state RUN; halt_req=0, paused=0, pause_src=0, timeout_err=0; toggle cleared; debounce counter 0, debounced level 0.
//  Reset mid-operation: any state -> RUN at that edge; halt_req drops on that edge; no timeout_err.
//  Button: debounced level changes after DEBOUNCE_CYC consecutive equal samples; toggle flips on debounced rising edge.
//  Presses during reset ignored. Debounced level and toggle held at 0 while reset is high.
//  active = toggle | (osd_status & options[0]) | |ext_req.
//  vbl_rise = vblank & ~vblank_d (vblank_d registered).
//  FSM:
//   RUN      halt_req=0. active -> WAIT_VBL.
//   WAIT_VBL halt_req=0. !active -> RUN. else vbl_rise -> WAIT_ACK, halt_req=1 from next cycle.
//   WAIT_ACK halt_req=1, ack_cnt counts.
//            halt_ack -> PAUSED: paused=1, latch pause_src.
//            ack_cnt==ACK_TIMEOUT-1 -> PAUSED, timeout_err pulse.
//            Source drop is ignored here; PAUSED handles it.
//   PAUSED   halt_req=1, paused=1. pause_src ORs in newly active sources, cleared only on exit.
//            !active -> RELEASE: halt_req=0, paused=0 next cycle.
//   RELEASE  halt_req=0. !halt_ack -> RUN.
//            ack_cnt==ACK_TIMEOUT-1 -> RUN, timeout_err pulse.
//            A re-request here is serviced only after RUN (no shortcut).
//  ack_cnt width $clog2(ACK_TIMEOUT); cleared on every state entry; saturates, never wraps.
//  Simultaneous vbl_rise and source drop in WAIT_VBL -> RUN (drop wins).
//  Exit needs no vblank; entry always aligns to vblank.
// CONFIGURATION
//  PAUSE_FRAME_STEP_EN defined:
//   adds port step_button (in, 1), debounced via the same debounce submodule.
//   Debounced rising edge in PAUSED -> STEP: halt_req=0, paused=0; waits halt_ack low, then next vbl_rise -> WAIT_ACK.
//   Result: exactly one frame runs. If !active during STEP, go to RUN instead of WAIT_ACK.
//   step_button edges outside PAUSED are ignored.
//  PAUSE_FRAME_STEP_EN undefined: no step_button port, no STEP state; FSM exactly as above.
// STRUCTURE
//  pause_pkg: state enum {RUN, WAIT_VBL, WAIT_ACK, PAUSED, RELEASE, STEP};
//   localparams SRC_USER=0, SRC_OSD=1, SRC_EXT=2.
//  Sub-module pause_debounce (param DEBOUNCE_CYC; clk_sys, reset, din -> level, rise).
//   One instance for user_button, a second for step_button when PAUSE_FRAME_STEP_EN is defined.
//  Sequencer FSM, ack counter and source latch live in pause_sequencer.
// TESTING (bench: DEBOUNCE_CYC=4, ACK_TIMEOUT=8, NREQ=2)
//  1 ext_req=01, vblank rises at cycle 20, halt_ack 3 cycles after halt_req -> halt_req=1 at 21; paused=1 with pause_src=0100.
//    Drop ext_req -> halt_req=0 next cycle; halt_ack low -> RUN.
//  2 user_button high for 3 cycles -> no toggle.
//    High for 6 cycles -> pause taken at next vblank.
//    Second 6-cycle press -> release; reset while PAUSED -> halt_req=0 at that edge, toggle=0.
//  3 osd_status=1 with options=00 -> stays RUN.
//    options=01 -> pauses at next vblank, pause_src=0010.
//  4 halt_ack held 0 in WAIT_ACK -> PAUSED after 8 cycles with a one-cycle timeout_err.
//    halt_ack stuck 1 in RELEASE -> RUN after 8 cycles with a one-cycle timeout_err.
//  5 ext_req drops on the vblank rise edge in WAIT_VBL -> RUN, halt_req never asserted.
//  6 PAUSE_FRAME_STEP_EN: step press while PAUSED -> halt_req low for one vblank-to-vblank frame, then PAUSED again.

Source files
------------

// File: rtl/pause_pkg.sv
// Shared types and constants for the pause sequencer.
package pause_pkg;

  // Sequencer states. STEP is only reachable when frame stepping is built in.
  typedef enum logic [2:0] {
    RUN      = 3'd0,
    WAIT_VBL = 3'd1,
    WAIT_ACK = 3'd2,
    PAUSED   = 3'd3,
    RELEASE  = 3'd4,
    STEP     = 3'd5
  } pause_state_t;

  // Bit positions inside the pause source mask.
  localparam int SRC_USER = 0;
  localparam int SRC_OSD  = 1;
  localparam int SRC_EXT  = 2;

  // States in which the CPU is asked to stay halted.
  function automatic logic holds_cpu(input pause_state_t s);
    return (s == WAIT_ACK) || (s == PAUSED);
  endfunction

endpackage

// File: rtl/pause_debounce.sv
// Button debouncer: two-flop synchronizer, then the level follows the input
// only after DEBOUNCE_CYC consecutive samples that differ from the current level.
// rise is a one-cycle pulse that coincides with the level going high.
module pause_debounce #(
  parameter int DEBOUNCE_CYC = 12000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic       sync1_reg;
  logic       sync2_reg;
  logic [CW-1:0] cnt_reg;
  logic       level_reg;
  logic       rise_reg;

  // Bring the raw button into clk_sys before it is compared against anything.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
    end
  end

  // Count consecutive disagreeing samples; accept the new level on the last one.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg   <= '0;
        level_reg <= sync2_reg;
        rise_reg  <= sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/pause_sequencer.sv
// Pause sequencer: merges user/OSD/external pause sources and walks the CPU
// halt handshake, entering pause only on a vblank rising edge.
// Optional feature macro: PAUSE_FRAME_STEP_EN (adds step_button and the STEP
// state, which lets exactly one frame run while paused).
module pause_sequencer
  import pause_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int DEBOUNCE_CYC = 12000,
  parameter int ACK_TIMEOUT  = 4096
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            user_button,
  input  logic            osd_status,
  input  logic [1:0]      options,
  input  logic [NREQ-1:0] ext_req,
  input  logic            vblank,
  input  logic            halt_ack,
`ifdef PAUSE_FRAME_STEP_EN
  input  logic            step_button,
`endif
  output logic            halt_req,
  output logic            paused,
  output logic [NREQ+1:0] pause_src,
  output logic            timeout_err
);

  localparam int ACW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACW-1:0] ACK_LAST = ACW'(ACK_TIMEOUT - 1);

  pause_state_t    state_reg;
  pause_state_t    state_next;
  logic [ACW-1:0]  ack_cnt_reg;
  logic            vblank_d_reg;
  logic            toggle_reg;
  logic            halt_req_reg;
  logic            paused_reg;
  logic [NREQ+1:0] pause_src_reg;
  logic [NREQ+1:0] pause_src_next;
  logic            timeout_err_reg;
  logic            timeout_err_next;

  logic            user_level;
  logic            user_rise;
  logic [NREQ+1:0] src_now;
  logic            active;
  logic            vbl_rise;
  logic            ack_last;

  // options[1] is reserved; user_level is only needed through its rise pulse.
  logic unused_opt;
  logic unused_user_level;
  assign unused_opt        = options[1];
  assign unused_user_level = user_level;

  pause_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_user_db (
    .clk_sys (clk_sys),
    .reset   (reset),
    .din     (user_button),
    .level   (user_level),
    .rise    (user_rise)
  );

`ifdef PAUSE_FRAME_STEP_EN
  logic step_level;
  logic step_rise;
  logic step_low_reg;
  logic unused_step_level;
  assign unused_step_level = step_level;

  pause_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step_db (
    .clk_sys (clk_sys),
    .reset   (reset),
    .din     (step_button),
    .level   (step_level),
    .rise    (step_rise)
  );

  // Remember that the CPU has dropped halt_ack since entering STEP.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      step_low_reg <= 1'b0;
    end else if (state_reg != STEP) begin
      step_low_reg <= 1'b0;
    end else if (!halt_ack) begin
      step_low_reg <= 1'b1;
    end
  end
`endif

  // Current source mask: user toggle, gated OSD, then one bit per requester.
  assign src_now[SRC_USER] = toggle_reg;
  assign src_now[SRC_OSD]  = osd_status & options[0];
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ext
      assign src_now[SRC_EXT + gi] = ext_req[gi];
    end
  endgenerate

  assign active   = |src_now;
  assign vbl_rise = vblank & ~vblank_d_reg;
  assign ack_last = (ack_cnt_reg == ACK_LAST);

  // Button toggle and vblank edge history.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      toggle_reg   <= 1'b0;
      vblank_d_reg <= 1'b0;
    end else begin
      toggle_reg   <= toggle_reg ^ user_rise;
      vblank_d_reg <= vblank;
    end
  end

  // Next-state logic; entry always waits for vblank, exit never does.
  always_comb begin
    state_next       = state_reg;
    timeout_err_next = 1'b0;
    case (state_reg)
      RUN: begin
        if (active) state_next = WAIT_VBL;
      end
      WAIT_VBL: begin
        // A source dropping on the vblank edge wins over entry.
        if (!active)       state_next = RUN;
        else if (vbl_rise) state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        // Source drops are deliberately ignored until PAUSED is reached.
        if (halt_ack) begin
          state_next = PAUSED;
        end else if (ack_last) begin
          state_next       = PAUSED;
          timeout_err_next = 1'b1;
        end
      end
      PAUSED: begin
        if (!active) state_next = RELEASE;
`ifdef PAUSE_FRAME_STEP_EN
        else if (step_rise) state_next = STEP;
`endif
      end
      RELEASE: begin
        if (!halt_ack) begin
          state_next = RUN;
        end else if (ack_last) begin
          state_next       = RUN;
          timeout_err_next = 1'b1;
        end
      end
      STEP: begin
`ifdef PAUSE_FRAME_STEP_EN
        if (!active)                        state_next = RUN;
        else if (step_low_reg && vbl_rise)  state_next = WAIT_ACK;
`else
        state_next = RUN;
`endif
      end
      default: state_next = RUN;
    endcase
  end

  // Source mask: latched on PAUSED entry, accumulates while paused, zero elsewhere.
  always_comb begin
    pause_src_next = '0;
    if (state_next == PAUSED) begin
      pause_src_next = (state_reg == PAUSED) ? (pause_src_reg | src_now) : src_now;
    end
  end

  // State register and registered outputs derived from the next state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg       <= RUN;
      halt_req_reg    <= 1'b0;
      paused_reg      <= 1'b0;
      pause_src_reg   <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      halt_req_reg    <= holds_cpu(state_next);
      paused_reg      <= (state_next == PAUSED);
      pause_src_reg   <= pause_src_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  // Handshake wait counter: restarts on every state change and saturates.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ack_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      ack_cnt_reg <= '0;
    end else if ((state_reg == WAIT_ACK || state_reg == RELEASE) && !ack_last) begin
      ack_cnt_reg <= ack_cnt_reg + ACW'(1);
    end
  end

  assign halt_req    = halt_req_reg;
  assign paused      = paused_reg;
  assign pause_src   = pause_src_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_pause_sequencer.sv
// Directed bench for pause_sequencer with DEBOUNCE_CYC=4, ACK_TIMEOUT=8, NREQ=2.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_pause_sequencer;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       user_button;
  logic       osd_status;
  logic [1:0] options;
  logic [1:0] ext_req;
  logic       vblank;
  logic       halt_ack;
  logic       halt_req;
  logic       paused;
  logic [3:0] pause_src;
  logic       timeout_err;
`ifdef PAUSE_FRAME_STEP_EN
  logic       step_button;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       osd;
    logic [1:0] opt;
    logic [1:0] ext;
    logic       vbl;
    logic       ack;
    logic       exp_hr;
    logic       exp_p;
    logic [3:0] exp_src;
    logic       exp_terr;
  } vec_t;

  vec_t vecs[$];

  pause_sequencer #(.NREQ(2), .DEBOUNCE_CYC(4), .ACK_TIMEOUT(8)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .user_button (user_button),
    .osd_status  (osd_status),
    .options     (options),
    .ext_req     (ext_req),
    .vblank      (vblank),
    .halt_ack    (halt_ack),
`ifdef PAUSE_FRAME_STEP_EN
    .step_button (step_button),
`endif
    .halt_req    (halt_req),
    .paused      (paused),
    .pause_src   (pause_src),
    .timeout_err (timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Cycle-by-cycle vectors: inputs for one cycle, outputs expected after that edge.
    //                 osd   opt    ext    vbl   ack   hr    p     src      terr
    // ext_req[0] pause, release, drop ignored in WAIT_ACK
    vecs.push_back('{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    // drop on the vblank edge wins; source mask accumulates while paused
    vecs.push_back('{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1100, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1100, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    // OSD gated by options[0]; options[1] ignored
    vecs.push_back('{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});

    reset = 1'b1; user_button = 1'b1; osd_status = 1'b0; options = 2'b00;
    ext_req = 2'b00; vblank = 1'b0; halt_ack = 1'b0;
`ifdef PAUSE_FRAME_STEP_EN
    step_button = 1'b0;
`endif

    // Reset state, with the button held during reset (must be ignored).
    tick(8);
    chk("reset halt_req", {7'd0, halt_req}, 8'd0);
    chk("reset paused", {7'd0, paused}, 8'd0);
    chk("reset pause_src", {4'd0, pause_src}, 8'd0);
    chk("reset timeout_err", {7'd0, timeout_err}, 8'd0);
    $display("reset: halt_req=%0b paused=%0b src=%b", halt_req, paused, pause_src);
    user_button = 1'b0; reset = 1'b0;
    tick(8);
    vblank = 1'b1; tick(1);
    chk("press during reset ignored", {7'd0, halt_req}, 8'd0);
    vblank = 1'b0; tick(1);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      osd_status = vecs[i].osd; options = vecs[i].opt; ext_req = vecs[i].ext;
      vblank = vecs[i].vbl; halt_ack = vecs[i].ack;
      tick(1);
      $display("row %0d: ext=%b osd=%b opt=%b vbl=%b ack=%b -> hr=%b p=%b src=%b terr=%b",
               i, vecs[i].ext, vecs[i].osd, vecs[i].opt, vecs[i].vbl, vecs[i].ack,
               halt_req, paused, pause_src, timeout_err);
      chk($sformatf("row%0d halt_req", i), {7'd0, halt_req}, {7'd0, vecs[i].exp_hr});
      chk($sformatf("row%0d paused", i), {7'd0, paused}, {7'd0, vecs[i].exp_p});
      chk($sformatf("row%0d pause_src", i), {4'd0, pause_src}, {4'd0, vecs[i].exp_src});
      chk($sformatf("row%0d timeout_err", i), {7'd0, timeout_err}, {7'd0, vecs[i].exp_terr});
    end
    osd_status = 1'b0; options = 2'b00; ext_req = 2'b00; vblank = 1'b0; halt_ack = 1'b0;
    tick(2);

    // Short press: no toggle.
    user_button = 1'b1; tick(3); user_button = 1'b0; tick(10);
    vblank = 1'b1; tick(1);
    chk("short press no pause", {7'd0, halt_req}, 8'd0);
    $display("short press: halt_req=%0b", halt_req);
    vblank = 1'b0; tick(1);

    // Long press: toggle on, pause at the next vblank.
    user_button = 1'b1; tick(6); user_button = 1'b0; tick(2);
    chk("toggle waits vblank", {7'd0, halt_req}, 8'd0);
    vblank = 1'b1; tick(1);
    chk("toggle halt_req", {7'd0, halt_req}, 8'd1);
    vblank = 1'b0; halt_ack = 1'b1; tick(1);
    chk("toggle paused", {7'd0, paused}, 8'd1);
    chk("toggle pause_src", {4'd0, pause_src}, 8'h01);
    $display("toggle pause: paused=%0b src=%b", paused, pause_src);
    tick(8);

    // Second press: release.
    user_button = 1'b1; tick(6); user_button = 1'b0; tick(2);
    chk("toggle release paused", {7'd0, paused}, 8'd0);
    chk("toggle release halt_req", {7'd0, halt_req}, 8'd0);
    $display("toggle release: paused=%0b halt_req=%0b", paused, halt_req);
    halt_ack = 1'b0; tick(8);

    // Third press, then reset while paused.
    user_button = 1'b1; tick(6); user_button = 1'b0; tick(2);
    vblank = 1'b1; tick(1);
    vblank = 1'b0; halt_ack = 1'b1; tick(1);
    chk("pre-reset paused", {7'd0, paused}, 8'd1);
    reset = 1'b1; tick(1);
    chk("mid reset halt_req", {7'd0, halt_req}, 8'd0);
    chk("mid reset paused", {7'd0, paused}, 8'd0);
    chk("mid reset pause_src", {4'd0, pause_src}, 8'd0);
    chk("mid reset timeout_err", {7'd0, timeout_err}, 8'd0);
    $display("mid reset: halt_req=%0b paused=%0b", halt_req, paused);
    tick(1);
    reset = 1'b0; halt_ack = 1'b0; tick(2);
    vblank = 1'b1; tick(1);
    chk("toggle cleared by reset", {7'd0, halt_req}, 8'd0);
    vblank = 1'b0; tick(1);

    // Ack never arrives: timeout into PAUSED.
    ext_req = 2'b01; tick(1);
    vblank = 1'b1; tick(1);
    vblank = 1'b0; tick(7);
    chk("ack wait not yet paused", {7'd0, paused}, 8'd0);
    chk("ack wait no early timeout", {7'd0, timeout_err}, 8'd0);
    tick(1);
    chk("ack timeout paused", {7'd0, paused}, 8'd1);
    chk("ack timeout pulse", {7'd0, timeout_err}, 8'd1);
    $display("ack timeout: paused=%0b timeout_err=%0b", paused, timeout_err);
    tick(1);
    chk("ack timeout one cycle", {7'd0, timeout_err}, 8'd0);
    chk("ack timeout stays paused", {7'd0, paused}, 8'd1);

    // Ack stuck high on release: timeout into RUN, re-request only after RUN.
    halt_ack = 1'b1; ext_req = 2'b00; tick(1);
    chk("release halt_req", {7'd0, halt_req}, 8'd0);
    ext_req = 2'b01; tick(7);
    chk("release no early timeout", {7'd0, timeout_err}, 8'd0);
    tick(1);
    chk("release timeout pulse", {7'd0, timeout_err}, 8'd1);
    $display("release timeout: timeout_err=%0b halt_req=%0b", timeout_err, halt_req);
    tick(1);
    chk("release timeout one cycle", {7'd0, timeout_err}, 8'd0);
    vblank = 1'b1; tick(1);
    chk("re-request after RUN", {7'd0, halt_req}, 8'd1);
    vblank = 1'b0; tick(1);
    chk("re-request paused", {7'd0, paused}, 8'd1);
    ext_req = 2'b00; tick(1);
    halt_ack = 1'b0; tick(2);

`ifdef PAUSE_FRAME_STEP_EN
    // Frame step: one vblank-to-vblank frame with halt_req low, then paused again.
    ext_req = 2'b01; tick(1);
    vblank = 1'b1; tick(1);
    vblank = 1'b0; halt_ack = 1'b1; tick(1);
    chk("step pre paused", {7'd0, paused}, 8'd1);
    step_button = 1'b1; tick(6); step_button = 1'b0; tick(2);
    chk("step halt_req low", {7'd0, halt_req}, 8'd0);
    chk("step paused low", {7'd0, paused}, 8'd0);
    halt_ack = 1'b0; tick(2);
    chk("step waits vblank", {7'd0, halt_req}, 8'd0);
    vblank = 1'b1; tick(1);
    chk("step halt_req again", {7'd0, halt_req}, 8'd1);
    vblank = 1'b0; halt_ack = 1'b1; tick(1);
    chk("step paused again", {7'd0, paused}, 8'd1);
    $display("frame step: paused=%0b halt_req=%0b", paused, halt_req);
    ext_req = 2'b00; tick(1);
    halt_ack = 1'b0; tick(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
